// File: rtl/cp0_pkg.sv
// cp0_pkg: shared definitions for the cp0_vec coprocessor 0 slice.
//   - coprocessor register numbers reachable through MFC0/MTC0
//   - bit positions inside Status and Cause
//   - timer interrupt index and Compare reset value
//   - highest_idx(): fixed-priority encoder over the 8 IP/IM positions
// Optional feature macro used by the slice: CP0_TIMER_EN.
package cp0_pkg;

   localparam logic [4:0] REG_COUNT   = 5'd9;
   localparam logic [4:0] REG_COMPARE = 5'd11;
   localparam logic [4:0] REG_STATUS  = 5'd12;
   localparam logic [4:0] REG_CAUSE   = 5'd13;
   localparam logic [4:0] REG_EPC     = 5'd14;

   localparam int BIT_IE    = 0;
   localparam int BIT_EXL   = 1;
   localparam int IP_BASE   = 8;
   localparam int TIMER_BIT = 15;
   localparam int EXC_LSB   = 2;
   localparam int EXC_MSB   = 6;

   localparam logic [2:0]  TIMER_IDX   = 3'd7;
   localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

   // Highest set bit wins: timer (bit 7) beats every external line.
   function automatic logic [2:0] highest_idx(input logic [7:0] v);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (v[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer with a sticky match latch.
// Ports:
//   clock, reset     rising-edge clock, synchronous active-high reset
//   wr_count         load Count from wr_data (suppresses that cycle's increment)
//   wr_compare       load Compare from wr_data and clear the pending latch
//   wr_data          MTC0 write data
//   count, compare   current register values
//   pending          set the edge after Count == Compare, held until Compare write
module cp0_timer
   import cp0_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        wr_count,
   input  logic        wr_compare,
   input  logic [31:0] wr_data,
   output logic [31:0] count,
   output logic [31:0] compare,
   output logic        pending
);

   logic [31:0] count_q, count_d;
   logic [31:0] compare_q, compare_d;
   logic        pending_q, pending_d;

   always_comb begin
      count_d   = wr_count ? wr_data : count_q + 32'd1;
      compare_d = wr_compare ? wr_data : compare_q;
      // A Compare write in the same cycle as a match leaves the latch clear.
      if (wr_compare)
         pending_d = 1'b0;
      else if (count_q == compare_q)
         pending_d = 1'b1;
      else
         pending_d = pending_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q   <= 32'd0;
         compare_q <= COMPARE_RST;
         pending_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         pending_q <= pending_d;
      end
   end

   assign count   = count_q;
   assign compare = compare_q;
   assign pending = pending_q;

endmodule

// File: rtl/cp0_vec.sv
// cp0_vec: coprocessor 0 with up to seven masked external interrupt lines
// plus an optional Count/Compare timer (macro CP0_TIMER_EN), fixed priority
// and the taken source latched into Cause.ExcCode.
// Parameters:
//   NUM_IRQ   external lines, 1..7, on IP/IM bits 8..8+NUM_IRQ-1
//   PC_WIDTH  word-address width of next_pc/EPC, up to 30
// Ports:
//   clock, reset    rising-edge clock, synchronous active-high reset
//   rd_data         combinational read of the register selected by regnum
//   EPC             saved word-address return PC
//   TakenInterrupt  combinational: an interrupt is taken this cycle
//   wr_data, regnum, MTC0   coprocessor register write port
//   next_pc         PC captured into EPC when an interrupt is taken
//   ERET            return from exception, clears EXL
//   irq_in          level-sensitive external requests
module cp0_vec #(
   parameter int NUM_IRQ  = 7,
   parameter int PC_WIDTH = 30
) (
   input  logic                clock,
   input  logic                reset,
   output logic [31:0]         rd_data,
   output logic [PC_WIDTH-1:0] EPC,
   output logic                TakenInterrupt,
   input  logic [31:0]         wr_data,
   input  logic [4:0]          regnum,
   input  logic [PC_WIDTH-1:0] next_pc,
   input  logic                MTC0,
   input  logic                ERET,
   input  logic [NUM_IRQ-1:0]  irq_in
);

   import cp0_pkg::*;

   localparam logic [7:0] EXT_MASK = 8'((1 << NUM_IRQ) - 1);
`ifdef CP0_TIMER_EN
   localparam logic [7:0] IM_MASK = EXT_MASK | 8'h80;
`else
   localparam logic [7:0] IM_MASK = EXT_MASK;
`endif

   logic [7:0]          im_q, im_d;
   logic                ie_q, ie_d;
   logic                exl_q, exl_d;
   logic [4:0]          exc_q, exc_d;
   logic [PC_WIDTH-1:0] epc_q, epc_d;

   logic [7:0] ip;
   logic [7:0] active;
   logic       timer_pending;
   logic       take;

`ifdef CP0_TIMER_EN
   logic [31:0] timer_count;
   logic [31:0] timer_compare;

   cp0_timer u_timer (
      .clock      (clock),
      .reset      (reset),
      .wr_count   (MTC0 && (regnum == REG_COUNT)),
      .wr_compare (MTC0 && (regnum == REG_COMPARE)),
      .wr_data    (wr_data),
      .count      (timer_count),
      .compare    (timer_compare),
      .pending    (timer_pending)
   );
`else
   assign timer_pending = 1'b0;
   // Bit 1 only feeds the timer registers, which are absent in this build.
   logic unused_wr_bit;
   assign unused_wr_bit = wr_data[1];
`endif

   // IP[8+i] follows irq_in[i] directly; positions beyond NUM_IRQ read 0.
   genvar gi;
   generate
      for (gi = 0; gi < 7; gi++) begin : g_ip
         if (gi < NUM_IRQ) begin : g_line
            assign ip[gi] = irq_in[gi];
         end else begin : g_none
            assign ip[gi] = 1'b0;
         end
      end
   endgenerate
   assign ip[7] = timer_pending;

   assign active         = ip & im_q;
   assign take           = (|active) & ie_q & ~exl_q;
   assign TakenInterrupt = take;
   assign EPC            = epc_q;

   always_comb begin
      im_d  = im_q;
      ie_d  = ie_q;
      exl_d = exl_q;
      exc_d = exc_q;
      epc_d = epc_q;

      // Status write proceeds even in a take cycle; EXL is handled below.
      if (MTC0 && (regnum == REG_STATUS)) begin
         im_d = wr_data[15:8] & IM_MASK;
         ie_d = wr_data[0];
      end

      if (take) begin
         exl_d = 1'b1;
         exc_d = {2'b00, highest_idx(active)};
         epc_d = next_pc;
      end else begin
         if (ERET) exl_d = 1'b0;
         if (MTC0 && (regnum == REG_EPC)) epc_d = wr_data[PC_WIDTH+1:2];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         im_q  <= 8'h00;
         ie_q  <= 1'b0;
         exl_q <= 1'b0;
         exc_q <= 5'd0;
         epc_q <= '0;
      end else begin
         im_q  <= im_d;
         ie_q  <= ie_d;
         exl_q <= exl_d;
         exc_q <= exc_d;
         epc_q <= epc_d;
      end
   end

   always_comb begin
      rd_data = 32'h0;
      case (regnum)
         REG_STATUS: rd_data = {16'h0, im_q, 6'h0, exl_q, ie_q};
         REG_CAUSE:  rd_data = {16'h0, ip, 1'b0, exc_q, 2'b00};
         REG_EPC:    rd_data = 32'({epc_q, 2'b00});
`ifdef CP0_TIMER_EN
         REG_COUNT:   rd_data = timer_count;
         REG_COMPARE: rd_data = timer_compare;
`endif
         default:    rd_data = 32'h0;
      endcase
   end

endmodule
